spike_decoder: RTL and testbench

//  Output-side reader for the LIF spiking network: samples the network's output

---
 rtl/spike_decoder.sv | 120 ++++++++++++
 tb/tb_spike_decoder.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/spike_decoder.sv
// Spike-count window decoder: counts output spikes per class over WINDOW cycles, then argmax.
// Optional SPIKE_DECODER_COUNTS_EN exposes all per-class counts on res_counts.
module spike_decoder #(
   parameter int N_OUT  = 2,
   parameter int CNT_W  = 8,
   parameter int WINDOW = 64,
   parameter int CLS_W  = 1
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               start,
   input  logic [N_OUT-1:0]   spikes_in,
   output logic               busy,
   output logic               net_clr,
   output logic               res_valid,
   input  logic               res_ready,
   output logic [CLS_W-1:0]   res_class,
   output logic [CNT_W-1:0]   res_count,
`ifdef SPIKE_DECODER_COUNTS_EN
   output logic [N_OUT*CNT_W-1:0] res_counts,
`endif
   output logic               res_tie
);

   // state | meaning
   // IDLE  | waiting for start
   // COUNT | sampling spikes_in for WINDOW cycles
   // SCAN  | one class compared per cycle, then one cycle to settle the result
   // HOLD  | result presented, waiting for res_ready
   typedef enum logic [1:0] {IDLE, COUNT, SCAN, HOLD} state_t;

   localparam int TMR_W  = (WINDOW > 1) ? $clog2(WINDOW) : 1;
   localparam int SIDX_W = $clog2(N_OUT + 1);

   state_t              state_q, state_d;
   logic [TMR_W-1:0]    tmr_q;
   logic [SIDX_W-1:0]   scan_idx_q;
   logic [CNT_W-1:0]    cnt_q [N_OUT];
   logic [CNT_W-1:0]    cur_cnt;
   logic [CNT_W-1:0]    best_cnt_q;
   logic [CLS_W-1:0]    best_idx_q;
   logic                tie_q;
   logic                net_clr_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = COUNT;
         COUNT:   if (tmr_q == '0) state_d = SCAN;
         SCAN:    if (scan_idx_q == SIDX_W'(N_OUT)) state_d = HOLD;
         HOLD:    if (res_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      cur_cnt = '0;
      for (int i = 0; i < N_OUT; i++)
         if (scan_idx_q == SIDX_W'(i)) cur_cnt = cnt_q[i];
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= IDLE;
         tmr_q      <= '0;
         scan_idx_q <= '0;
         best_cnt_q <= '0;
         best_idx_q <= '0;
         tie_q      <= 1'b0;
         net_clr_q  <= 1'b0;
         for (int i = 0; i < N_OUT; i++) cnt_q[i] <= '0;
      end else begin
         state_q   <= state_d;
         net_clr_q <= (state_q == IDLE) && start;
         case (state_q)
            IDLE: if (start) begin
               for (int i = 0; i < N_OUT; i++) cnt_q[i] <= '0;
               tmr_q      <= TMR_W'(WINDOW - 1);
               scan_idx_q <= '0;
            end
            COUNT: begin
               for (int i = 0; i < N_OUT; i++)
                  if (spikes_in[i] && (cnt_q[i] != '1)) cnt_q[i] <= cnt_q[i] + 1'b1;
               if (tmr_q != '0) tmr_q <= tmr_q - 1'b1;
            end
            SCAN: if (scan_idx_q != SIDX_W'(N_OUT)) begin
               // strict > keeps the lowest index on ties; equal later max flags a tie
               if (scan_idx_q == '0) begin
                  best_cnt_q <= cur_cnt;
                  best_idx_q <= '0;
                  tie_q      <= 1'b0;
               end else if (cur_cnt > best_cnt_q) begin
                  best_cnt_q <= cur_cnt;
                  best_idx_q <= CLS_W'(scan_idx_q);
                  tie_q      <= 1'b0;
               end else if (cur_cnt == best_cnt_q) begin
                  tie_q      <= 1'b1;
               end
               scan_idx_q <= scan_idx_q + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign busy      = (state_q != IDLE);
   assign res_valid = (state_q == HOLD);
   assign net_clr   = net_clr_q;
   assign res_class = best_idx_q;
   assign res_count = best_cnt_q;
   assign res_tie   = tie_q;

`ifdef SPIKE_DECODER_COUNTS_EN
   // counters are frozen from end of COUNT until the next accepted start
   for (genvar g = 0; g < N_OUT; g++) begin : g_counts
      assign res_counts[g*CNT_W +: CNT_W] = cnt_q[g];
   end
`endif

endmodule

// File: tb/tb_spike_decoder.sv
// Randomised bench for spike_decoder: two instances (2x4b/8 and 3x3b/10) against a count/argmax model.
module tb_spike_decoder;

   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   logic       a_start, a_ready, a_busy, a_clr, a_valid, a_tie;
   logic [1:0] a_spk;
   logic [0:0] a_cls;
   logic [3:0] a_cnt;
   logic       b_start, b_ready, b_busy, b_clr, b_valid, b_tie;
   logic [2:0] b_spk;
   logic [1:0] b_cls;
   logic [2:0] b_cnt;
`ifdef SPIKE_DECODER_COUNTS_EN
   logic [7:0] a_counts;
   logic [8:0] b_counts;
`endif

   spike_decoder #(.N_OUT(2), .CNT_W(4), .WINDOW(8), .CLS_W(1)) u_dut_a (
      .clk(clk), .rstn(rstn), .start(a_start), .spikes_in(a_spk),
      .busy(a_busy), .net_clr(a_clr), .res_valid(a_valid), .res_ready(a_ready),
      .res_class(a_cls), .res_count(a_cnt),
`ifdef SPIKE_DECODER_COUNTS_EN
      .res_counts(a_counts),
`endif
      .res_tie(a_tie));

   spike_decoder #(.N_OUT(3), .CNT_W(3), .WINDOW(10), .CLS_W(2)) u_dut_b (
      .clk(clk), .rstn(rstn), .start(b_start), .spikes_in(b_spk),
      .busy(b_busy), .net_clr(b_clr), .res_valid(b_valid), .res_ready(b_ready),
      .res_class(b_cls), .res_count(b_cnt),
`ifdef SPIKE_DECODER_COUNTS_EN
      .res_counts(b_counts),
`endif
      .res_tie(b_tie));

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Count spikes per class with saturation, then pick the first maximum.
   function automatic void model(input int n, input int maxv, input int unsigned pat[$],
                                 output int cls, output int mx, output bit tie,
                                 output logic [63:0] packed_cnt, input int cw);
      int c[4];
      int nmax;
      for (int i = 0; i < 4; i++) c[i] = 0;
      foreach (pat[k])
         for (int i = 0; i < n; i++)
            if (pat[k][i] && c[i] < maxv) c[i]++;
      mx = -1; cls = 0; nmax = 0; packed_cnt = '0;
      for (int i = 0; i < n; i++) begin
         if (c[i] > mx) begin mx = c[i]; cls = i; end
         packed_cnt = packed_cnt | (64'(c[i]) << (i * cw));
      end
      for (int i = 0; i < n; i++) if (c[i] == mx) nmax++;
      tie = (nmax > 1);
   endfunction

   function automatic void gen_pat(input int n, input int len, output int unsigned pat[$]);
      int dens[4];
      pat = {};
      for (int i = 0; i < n; i++) dens[i] = $urandom_range(0, 8);
      for (int k = 0; k < len; k++) begin
         int unsigned v = 0;
         for (int i = 0; i < n; i++) if ($urandom_range(0, 7) < dens[i]) v |= (1 << i);
         pat.push_back(v);
      end
   endfunction

   task automatic run_a(input int unsigned pat[$], input int rdy_dly, input bit noise);
      int ecls, emx, edge_n;
      bit etie;
      logic [63:0] epk;
      model(2, 15, pat, ecls, emx, etie, epk, 4);
      @(negedge clk); a_start = 1'b1; a_ready = 1'b0;
      @(negedge clk);
      a_start = noise ? 1'($urandom) : 1'b0;
      chk("a_net_clr_pulse", a_clr, 1);
      chk("a_busy_count", a_busy, 1);
      a_spk = 2'(pat[0]);
      for (int k = 1; k < 8; k++) begin
         @(negedge clk);
         chk("a_net_clr_once", a_clr, 0);
         a_start = noise ? 1'($urandom) : 1'b0;
         a_spk = 2'(pat[k]);
      end
      edge_n = 7;
      for (int t = 0; t < 40; t++) begin
         @(negedge clk);
         edge_n++;
         a_spk = 2'($urandom);
         a_start = noise ? 1'($urandom) : 1'b0;
         if (a_valid) break;
      end
      a_start = 1'b0;
      chk("a_latency", edge_n, 11);
      for (int d = 0; d <= rdy_dly; d++) begin
         chk("a_valid", a_valid, 1);
         chk("a_class", a_cls, ecls);
         chk("a_count", a_cnt, emx);
         chk("a_tie", a_tie, etie);
`ifdef SPIKE_DECODER_COUNTS_EN
         chk("a_counts", a_counts, epk);
`endif
         if (d == rdy_dly) a_ready = 1'b1;
         @(negedge clk);
      end
      chk("a_valid_drop", a_valid, 0);
      chk("a_busy_idle", a_busy, 0);
      a_ready = 1'b0;
   endtask

   task automatic run_b(input int unsigned pat[$], input int rdy_dly);
      int ecls, emx, edge_n;
      bit etie;
      logic [63:0] epk;
      model(3, 7, pat, ecls, emx, etie, epk, 3);
      @(negedge clk); b_start = 1'b1; b_ready = 1'b0;
      @(negedge clk);
      b_start = 1'b0;
      chk("b_net_clr_pulse", b_clr, 1);
      b_spk = 3'(pat[0]);
      for (int k = 1; k < 10; k++) begin
         @(negedge clk);
         b_spk = 3'(pat[k]);
      end
      edge_n = 9;
      for (int t = 0; t < 40; t++) begin
         @(negedge clk);
         edge_n++;
         b_spk = 3'($urandom);
         if (b_valid) break;
      end
      chk("b_latency", edge_n, 14);
      for (int d = 0; d <= rdy_dly; d++) begin
         chk("b_class", b_cls, ecls);
         chk("b_count", b_cnt, emx);
         chk("b_tie", b_tie, etie);
`ifdef SPIKE_DECODER_COUNTS_EN
         chk("b_counts", b_counts, epk);
`endif
         if (d == rdy_dly) b_ready = 1'b1;
         @(negedge clk);
      end
      chk("b_valid_drop", b_valid, 0);
      b_ready = 1'b0;
   endtask

   initial begin
      int unsigned pat[$];
      int pulses[$];
      rstn = 1'b0;
      a_start = 0; a_ready = 0; a_spk = 0;
      b_start = 0; b_ready = 0; b_spk = 0;
      repeat (3) @(negedge clk);
      chk("rst_a_busy", a_busy, 0);
      chk("rst_a_clr", a_clr, 0);
      chk("rst_a_valid", a_valid, 0);
      chk("rst_a_res", {a_cls, a_cnt, a_tie}, 0);
      chk("rst_b_busy", b_busy, 0);
`ifdef SPIKE_DECODER_COUNTS_EN
      chk("rst_a_counts", a_counts, 0);
`endif
      rstn = 1'b1;

      // class 1 every cycle, class 0 alternate
      pat = {};
      for (int k = 0; k < 8; k++) pat.push_back((k % 2 == 0) ? 3 : 2);
      run_a(pat, 0, 1'b0);
      // both high: tie resolves to class 0, held under backpressure with start noise
      pat = {3, 3, 3, 3, 3, 3, 3, 3};
      run_a(pat, 5, 1'b1);
      pat = {0, 0, 0, 0, 0, 0, 0, 0};
      run_a(pat, 1, 1'b0);
      for (int r = 0; r < 8; r++) begin
         gen_pat(2, 8, pat);
         run_a(pat, $urandom_range(0, 3), 1'b1);
      end

      // saturation on the 3-bit / 10-cycle instance
      pat = {};
      for (int k = 0; k < 10; k++) pat.push_back(1);
      run_b(pat, 2);
      for (int r = 0; r < 6; r++) begin
         gen_pat(3, 10, pat);
         run_b(pat, $urandom_range(0, 2));
      end

      // reset in the middle of a window
      @(negedge clk); a_start = 1'b1;
      @(negedge clk); a_start = 1'b0; a_spk = 2'b11;
      repeat (3) @(negedge clk);
      rstn = 1'b0;
      #1;
      chk("midrst_busy", a_busy, 0);
      chk("midrst_valid", a_valid, 0);
      chk("midrst_clr", a_clr, 0);
      @(negedge clk); rstn = 1'b1;
      pat = {1, 0, 1, 1, 0, 0, 1, 0};
      run_a(pat, 0, 1'b0);

      // start held high with full ready: one net_clr per 13 cycles
      @(negedge clk); a_start = 1'b1; a_ready = 1'b1;
      for (int c = 1; c <= 45; c++) begin
         @(negedge clk);
         a_spk = 2'($urandom);
         if (a_clr) pulses.push_back(c);
      end
      a_start = 1'b0;
      chk("stream_pulses", pulses.size(), 4);
      for (int i = 1; i < pulses.size(); i++)
         chk("stream_period", pulses[i] - pulses[i-1], 13);
      repeat (25) @(negedge clk);
      chk("stream_drain_idle", a_busy, 0);
      a_ready = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
